grant_sequencer: RTL and testbench

GRANT_SEQUENCER -- requirements
Module: grant_sequencer

---
 rtl/grant_sequencer.sv | 133 +++++++++++++
 tb/tb_grant_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/grant_sequencer.sv
// Single-grant sequencer: registers the upstream encoded request, holds it until accepted or timed out, then cools down.
// Optional macro GRANT_CNT_EN enables the saturating accepted-grant counter on grant_cnt.
module grant_sequencer #(
  parameter int unsigned HOLD_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_idx,
  input  logic        req_valid,
  input  logic        gnt_ready,
  output logic        gnt_valid,
  output logic [1:0]  gnt_idx,
  output logic [3:0]  gnt_onehot,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] grant_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] COOL  = 2'd2;

  localparam logic [1:0] AFTER_GRANT = (HOLD_CYCLES == 0) ? IDLE : COOL;
  localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] HOLD_LAST   = 4'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [7:0] wait_cnt_r;
  logic [7:0] wait_cnt_nxt_s;
  logic [3:0] hold_cnt_r;
  logic [3:0] hold_cnt_nxt_s;
  logic [1:0] gnt_idx_nxt_s;
  logic       timeout_nxt_s;
  logic       handshake_s;
  logic       expire_s;

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    case (idx)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  // The handshake wins over an expiring wait in the same cycle.
  assign handshake_s = (state_r == GRANT) && gnt_valid && gnt_ready;
  assign expire_s    = (state_r == GRANT) && !handshake_s && (wait_cnt_r == WAIT_LAST);

  // Next-state, counter and grant-index decision.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    hold_cnt_nxt_s = hold_cnt_r;
    gnt_idx_nxt_s  = gnt_idx;
    timeout_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_nxt_s    = GRANT;
          wait_cnt_nxt_s = 8'd0;
          gnt_idx_nxt_s  = req_idx;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (handshake_s || expire_s) begin
          state_nxt_s    = AFTER_GRANT;
          hold_cnt_nxt_s = 4'd0;
          timeout_nxt_s  = expire_s;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + 8'd1;
        end
      end
      COOL: begin
        if (hold_cnt_r == HOLD_LAST) begin
          state_nxt_s    = IDLE;
          hold_cnt_nxt_s = 4'd0;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + 4'd1;
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        wait_cnt_nxt_s = 8'd0;
        hold_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // State, counters and all outputs are registered from the next-state view.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      wait_cnt_r  <= 8'd0;
      hold_cnt_r  <= 4'd0;
      gnt_idx     <= 2'd0;
      gnt_valid   <= 1'b0;
      gnt_onehot  <= 4'b0000;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      wait_cnt_r  <= wait_cnt_nxt_s;
      hold_cnt_r  <= hold_cnt_nxt_s;
      gnt_idx     <= gnt_idx_nxt_s;
      gnt_valid   <= (state_nxt_s == GRANT);
      gnt_onehot  <= (state_nxt_s == GRANT) ? idx_to_onehot(gnt_idx_nxt_s) : 4'b0000;
      busy        <= (state_nxt_s != IDLE);
      timeout_err <= timeout_nxt_s;
    end
  end

`ifdef GRANT_CNT_EN
  // Saturating count of accepted grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= 16'd0;
    end else if (handshake_s && (grant_cnt != 16'hFFFF)) begin
      grant_cnt <= grant_cnt + 16'd1;
    end
  end
`else
  assign grant_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_grant_sequencer.sv
// Randomized self-checking bench for grant_sequencer: two instances (HOLD_CYCLES=2 and 0) against a cycle-level reference model.
module tb_grant_sequencer;

`ifdef GRANT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_idx = 2'd0;
  logic        req_valid = 1'b0;
  logic        gnt_ready = 1'b0;
  logic        gv [2];
  logic [1:0]  gi [2];
  logic [3:0]  goh [2];
  logic        gbusy [2];
  logic        gtmo [2];
  logic [15:0] gcnt [2];

  int n_checks = 0;
  int n_fail = 0;

  // reference model state: one entry per instance
  int       m_hold [2] = '{2, 0};
  bit       m_valid [2];
  int       m_age [2];
  int       m_cool [2];
  bit [1:0] m_idx [2];
  bit       m_tmo [2];
  int       m_cnt [2];
  string    nm [2] = '{"hold2", "hold0"};

  always #5 clk = ~clk;

  grant_sequencer #(.HOLD_CYCLES(2), .TIMEOUT_CYCLES(TIMEOUT)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_idx(req_idx), .req_valid(req_valid), .gnt_ready(gnt_ready),
    .gnt_valid(gv[0]), .gnt_idx(gi[0]), .gnt_onehot(goh[0]), .busy(gbusy[0]),
    .timeout_err(gtmo[0]), .grant_cnt(gcnt[0]));

  grant_sequencer #(.HOLD_CYCLES(0), .TIMEOUT_CYCLES(TIMEOUT)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_idx(req_idx), .req_valid(req_valid), .gnt_ready(gnt_ready),
    .gnt_valid(gv[1]), .gnt_idx(gi[1]), .gnt_onehot(goh[1]), .busy(gbusy[1]),
    .timeout_err(gtmo[1]), .grant_cnt(gcnt[1]));

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0; m_age[i] = 0; m_cool[i] = 0;
      m_idx[i] = 2'd0; m_tmo[i] = 1'b0; m_cnt[i] = 0;
    end
  endtask

  // advance the model by one rising edge using the inputs currently applied
  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_tmo[i] = 1'b0;
        if (m_valid[i]) begin
          m_age[i]++;
          if (gnt_ready) begin
            m_valid[i] = 1'b0;
            m_cool[i] = m_hold[i];
            if (m_cnt[i] < 65535) m_cnt[i]++;
          end else if (m_age[i] == TIMEOUT) begin
            m_valid[i] = 1'b0;
            m_tmo[i] = 1'b1;
            m_cool[i] = m_hold[i];
          end
        end else if (m_cool[i] > 0) begin
          m_cool[i]--;
        end else if (req_valid) begin
          m_valid[i] = 1'b1;
          m_idx[i] = req_idx;
          m_age[i] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check_eq({nm[i], ".gnt_valid"}, 16'(gv[i]), 16'(m_valid[i]));
      check_eq({nm[i], ".gnt_idx"}, 16'(gi[i]), 16'(m_idx[i]));
      check_eq({nm[i], ".gnt_onehot"}, 16'(goh[i]), m_valid[i] ? (16'd1 << m_idx[i]) : 16'd0);
      check_eq({nm[i], ".busy"}, 16'(gbusy[i]), 16'(m_valid[i] || (m_cool[i] > 0)));
      check_eq({nm[i], ".timeout_err"}, 16'(gtmo[i]), 16'(m_tmo[i]));
      check_eq({nm[i], ".grant_cnt"}, gcnt[i], CNT_EN ? 16'(m_cnt[i]) : 16'd0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  // reset pulled low between edges; outputs must clear before the next edge
  task automatic async_reset_pulse();
    @(posedge clk);
    model_step();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq({nm[i], ".rst_gnt_valid"}, 16'(gv[i]), 16'd0);
      check_eq({nm[i], ".rst_gnt_onehot"}, 16'(goh[i]), 16'd0);
      check_eq({nm[i], ".rst_busy"}, 16'(gbusy[i]), 16'd0);
      check_eq({nm[i], ".rst_timeout_err"}, 16'(gtmo[i]), 16'd0);
      check_eq({nm[i], ".rst_grant_cnt"}, gcnt[i], 16'd0);
    end
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    int prob_tbl [6] = '{80, 30, 0, 100, 50, 5};
    int prob;
    int high_cnt;

    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq({nm[i], ".reset_gnt_valid"}, 16'(gv[i]), 16'd0);
      check_eq({nm[i], ".reset_gnt_idx"}, 16'(gi[i]), 16'd0);
      check_eq({nm[i], ".reset_busy"}, 16'(gbusy[i]), 16'd0);
      check_eq({nm[i], ".reset_grant_cnt"}, gcnt[i], 16'd0);
    end

    // first grant on the first edge after reset release, then two cooldown cycles
    req_valid = 1'b1; req_idx = 2'b10; gnt_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check_eq("first_gnt_valid", 16'(gv[0]), 16'd1);
    check_eq("first_gnt_idx", 16'(gi[0]), 16'd2);
    check_eq("first_gnt_onehot", 16'(goh[0]), 16'h4);
    req_valid = 1'b0;
    cycle();
    check_eq("cool1_busy", 16'(gbusy[0]), 16'd1);
    cycle();
    check_eq("cool2_busy", 16'(gbusy[0]), 16'd1);
    cycle();
    check_eq("back_idle_busy", 16'(gbusy[0]), 16'd0);

    // timeout: idx 3 held, never accepted
    req_valid = 1'b1; req_idx = 2'b11; gnt_ready = 1'b0;
    cycle();
    high_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (gv[0]) high_cnt++;
      if (!gv[0]) break;
      if (k == 0) req_valid = 1'b0;
      cycle();
    end
    check_eq("timeout_high_cycles", 16'(high_cnt), 16'(TIMEOUT));
    check_eq("timeout_pulse", 16'(gtmo[0]), 16'd1);
    cycle();
    check_eq("timeout_pulse_end", 16'(gtmo[0]), 16'd0);
    repeat (3) cycle();

    // handshake in the final wait cycle wins over the timeout
    req_valid = 1'b1; req_idx = 2'b01; gnt_ready = 1'b0;
    cycle();
    req_valid = 1'b0;
    repeat (TIMEOUT - 1) cycle();
    check_eq("last_wait_valid", 16'(gv[0]), 16'd1);
    gnt_ready = 1'b1;
    cycle();
    check_eq("late_hs_no_tmo", 16'(gtmo[0]), 16'd0);
    check_eq("late_hs_valid", 16'(gv[0]), 16'd0);
    gnt_ready = 1'b0;
    repeat (3) cycle();

    // request index changes while granted are ignored until the next grant
    req_valid = 1'b1; req_idx = 2'b01;
    cycle();
    req_idx = 2'b11;
    cycle(); cycle();
    check_eq("stable_idx", 16'(gi[0]), 16'd1);
    gnt_ready = 1'b1;
    cycle();
    gnt_ready = 1'b0;
    repeat (3) cycle();
    check_eq("next_grant_idx", 16'(gi[0]), 16'd3);
    check_eq("next_grant_valid", 16'(gv[0]), 16'd1);

    // asynchronous reset in the middle of a grant
    async_reset_pulse();
    req_valid = 1'b0; gnt_ready = 1'b0;
    cycle();
    check_eq("post_rst_no_tmo", 16'(gtmo[0]), 16'd0);

    // zero-cooldown instance alternates grant/idle under continuous traffic
    req_valid = 1'b1; req_idx = 2'b00; gnt_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check_eq("hold0_pattern", 16'(gv[1]), (k % 2 == 0) ? 16'd1 : 16'd0);
    end
    check_eq("hold0_cnt3", gcnt[1], CNT_EN ? 16'd3 : 16'd0);

    // randomized traffic with varying acceptance rates
    for (int n = 0; n < 3000; n++) begin
      prob = prob_tbl[(n / 500) % 6];
      req_valid = ($urandom_range(0, 3) != 0);
      req_idx = 2'($urandom_range(0, 3));
      gnt_ready = ($urandom_range(0, 99) < prob);
      if ($urandom_range(0, 299) == 0) async_reset_pulse();
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
